// File: rtl/priority_arbiter.sv
// priority_arbiter: registered N-way fixed/round-robin arbiter with a valid/ready grant interface.
// Optional gnt_count_o handshake counter is enabled by defining PRIORITY_ARBITER_STATS_EN.
module priority_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ARB_MODE = 1,
    localparam int W = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               gnt_valid_o,
    input  logic               gnt_ready_i,
    output logic [W-1:0]       gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_onehot_o
`ifdef PRIORITY_ARBITER_STATS_EN
    ,
    output logic [31:0]        gnt_count_o
`endif
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state;
    logic [W-1:0]       r_idx;
    logic [NUM_REQ-1:0] r_onehot;
    logic [W-1:0]       r_prio_top;
    logic               w_hs;
    logic [NUM_REQ-1:0] w_mask;
    logic [W-1:0]       w_top;
    logic [W-1:0]       w_win;
    logic [NUM_REQ-1:0] w_win_oh;

    // Wrap modulo NUM_REQ so non-power-of-two sizes never index past NUM_REQ-1.
    function automatic logic [W-1:0] wrap_idx(input int t, input int i);
        return W'((t >= i) ? t - i : t - i + NUM_REQ);
    endfunction

    assign w_hs = (r_state == GRANT) && gnt_ready_i;
    assign w_mask = (r_state == GRANT) ? (req_i & ~r_onehot) : req_i;
    assign w_top = (ARB_MODE == 0) ? W'(NUM_REQ - 1) : r_prio_top;
    assign w_win_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_mask[wrap_idx(int'(w_top), i)]) w_win = wrap_idx(int'(w_top), i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_onehot   <= '0;
            r_prio_top <= W'(NUM_REQ - 1);
        end else begin
            if (r_state == IDLE || w_hs) begin
                r_state  <= (w_mask != '0) ? GRANT : IDLE;
                r_idx    <= (w_mask != '0) ? w_win : '0;
                r_onehot <= (w_mask != '0) ? w_win_oh : '0;
            end
            if (w_hs && ARB_MODE != 0)
                r_prio_top <= (r_idx == '0) ? W'(NUM_REQ - 1) : r_idx - 1'b1;
        end
    end

`ifdef PRIORITY_ARBITER_STATS_EN
    logic [31:0] r_gnt_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_gnt_count <= '0;
        else if (w_hs) r_gnt_count <= r_gnt_count + 32'd1;
    end

    assign gnt_count_o = r_gnt_count;
`endif

    assign gnt_valid_o = (r_state == GRANT);
    assign gnt_idx_o = r_idx;
    assign gnt_onehot_o = r_onehot;
endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Registered, parametrised N-way arbiter built on the priority-encoding function. It selects one requester among `NUM_REQ` request lines using either fixed (highest-index) or round-robin priority. It presents the winner on a valid/ready grant interface and holds the grant stable until the consumer accepts it. It sits between multiple request sources and a shared single-consumer resource such as a bus port or FIFO write side.

## Interface
Parameters:
- `NUM_REQ`, default 8: number of requesters; must be ≥2.
- `ARB_MODE`, default 1: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `req_i` input `NUM_REQ`: request lines; bit k = requester k.
- `gnt_valid_o` output 1: a grant is presented.
- `gnt_ready_i` input 1: consumer accepts the grant this cycle.
- `gnt_idx_o` output `$clog2(NUM_REQ)`: binary index of the granted requester.
- `gnt_onehot_o` output `NUM_REQ`: one-hot form of `gnt_idx_o`; all zero when not valid.

## Operation
- States:
  - `IDLE`: no grant is outstanding.
  - `GRANT`: `gnt_valid_o`=1.
- `IDLE` → `GRANT`: taken when `req_i`≠0. The winner is computed from `req_i` and registered.
- In `GRANT`, `gnt_idx_o`/`gnt_onehot_o` are frozen until handshake (`gnt_valid_o & gnt_ready_i`). This holds even if `req_i` changes or drops.
- On handshake, the next arbitration uses `req_i & ~gnt_onehot_o` with the updated priority:
  - If nonzero: the new winner is registered and the block stays in `GRANT`.
  - If zero: the block goes to `IDLE`.
- Fixed mode:
  - Winner = highest set index.
  - Priority state is unused.
- Round-robin mode:
  - Register `prio_top` holds the highest-priority index.
  - Search runs descending from `prio_top` with wrap: `prio_top`, `prio_top`-1, …, 0, `NUM_REQ`-1, …, `prio_top`+1.
  - On handshake of grant k: `prio_top` ← k-1, or `NUM_REQ`-1 when k=0.
  - `prio_top` changes only on handshake.
- `NUM_REQ` need not be a power of two. Wrap is computed modulo `NUM_REQ`, never modulo 2^width.
- Exactly one bit of `gnt_onehot_o` is set whenever `gnt_valid_o`=1.

## Timing
- Reset values: `gnt_valid_o`=0, `gnt_idx_o`=0, `gnt_onehot_o`=0, state `IDLE`, `prio_top`=`NUM_REQ`-1.
- Latency:
  - `req_i` sampled at edge N produces a grant visible after edge N (one cycle).
  - No combinational path from `req_i` or `gnt_ready_i` to any output.
- Throughput: one grant per cycle when `gnt_ready_i` is held 1 and ≥2 requesters are active.
- `gnt_ready_i` while `gnt_valid_o`=0 is ignored.
- Reset asserted mid-grant clears all outputs immediately (asynchronously) with no handshake. After release, arbitration restarts from `prio_top`=`NUM_REQ`-1.
- Simultaneous handshake and new requests: new requests participate in the arbitration made on the handshake edge.

## Configuration
- Macro `PRIORITY_ARBITER_STATS_EN`.
- Defined:
  - Adds output `gnt_count_o` [31:0].
  - It increments by 1 on every handshake, wraps at 2^32, and resets to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset/idle: assert `rst_i` with `req_i`=8'hFF mid-grant → all outputs 0 in the same cycle. After release, the first grant is idx 7 one cycle later.
- Fixed mode, `NUM_REQ`=8, `req_i`=8'b0010_1100, `gnt_ready_i`=1 → grants 5, 3, 2 on consecutive cycles, then `gnt_valid_o`=0 once requesters drop.
- Round-robin, `NUM_REQ`=8, `req_i`=8'hFF held, ready=1 → idx sequence 7,6,5,4,3,2,1,0,7.
- Backpressure: `req_i`=8'h10, ready=0 for 5 cycles, `req_i` changed to 8'h80 meanwhile → `gnt_idx_o` stays 4 until ready. After the handshake, the next grant is 7.
- Non-power-of-two: `NUM_REQ`=5, round-robin, `req_i`=5'b10001 held → alternating 4,0,4,0. `prio_top` never exceeds 4.
- With `PRIORITY_ARBITER_STATS_EN`: 10 handshakes → `gnt_count_o`=10. Force the counter to 32'hFFFFFFFF, do one handshake → 0.
